srdl_apb_regif: RTL and testbench

- APB4 slave front end for a generated register block.
- Decodes each APB transfer into one-cycle per-register access strobes (acc / rd / wr / wdata) that drive the field instances.
- Captures the addressed register's read value and returns it with configurable wait states and error signalling.
- Sits directly upstream of the field instances, between the bus fabric and the register array.

---
 rtl/srdl_apb_regif.sv | 115 +++++++++++
 tb/tb_srdl_apb_regif.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/srdl_apb_regif.sv
// APB4 slave front end for a generated register block: turns each APB transfer into a
// single-cycle register access strobe and returns the captured read value with optional wait states.
module srdl_apb_regif #(
    parameter int NREGS        = 8,
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 12,
    parameter int WAIT_STATES  = 0,
    parameter int ERR_UNMAPPED = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    psel,
    input  logic                    penable,
    input  logic                    pwrite,
    input  logic [ADDR_W-1:0]       paddr,
    input  logic [DATA_W-1:0]       pwdata,
    input  logic [DATA_W/8-1:0]     pstrb,
    output logic                    pready,
    output logic [DATA_W-1:0]       prdata,
    output logic                    pslverr,
    output logic [NREGS-1:0]        reg_acc,
    output logic                    reg_rd,
    output logic                    reg_wr,
    output logic [DATA_W-1:0]       reg_wdata,
    output logic [DATA_W-1:0]       reg_wmask,
    input  logic [NREGS*DATA_W-1:0] reg_rdata
);
    // state  | meaning
    // IDLE   | waiting for an APB access phase
    // STROBE | single cycle: register strobes out, read value captured
    // WAIT   | counting down configured wait states
    // DONE   | pready (and pslverr) for one cycle
    typedef enum logic [1:0] {IDLE, STROBE, WAIT, DONE} state_t;

    localparam int         IDX_W     = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int         NBYTES    = DATA_W / 8;
    localparam logic [2:0] WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    state_t              state, state_nxt;
    logic [IDX_W-1:0]    idx_q;
    logic                write_q, mapped_q, noop_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [NBYTES-1:0]   strb_q;
    logic [2:0]          wait_cnt;

    logic                access, mapped_d, noop_d, strobe;
    logic [ADDR_W-3:0]   idx_full;
    logic [DATA_W-1:0]   rdata_sel;

    assign access   = psel && penable;
    assign idx_full = paddr[ADDR_W-1:2];
    assign mapped_d = (32'(idx_full) < 32'(NREGS)) && (paddr[1:0] == 2'b00);
    assign noop_d   = pwrite && (pstrb == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (access) state_nxt = STROBE;
            STROBE:  if (!access)               state_nxt = IDLE;
                     else if (WAIT_STATES > 0)  state_nxt = WAIT;
                     else                       state_nxt = DONE;
            WAIT:    if (!access)               state_nxt = IDLE;
                     else if (wait_cnt == 3'd0) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            idx_q    <= '0;
            write_q  <= 1'b0;
            mapped_q <= 1'b0;
            noop_q   <= 1'b0;
            wdata_q  <= '0;
            strb_q   <= '0;
            wait_cnt <= 3'd0;
            prdata   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && access) begin
                idx_q    <= paddr[2 +: IDX_W];
                write_q  <= pwrite;
                mapped_q <= mapped_d;
                noop_q   <= noop_d;
                wdata_q  <= pwdata;
                strb_q   <= pstrb;
            end
            if (state == STROBE)
                wait_cnt <= WAIT_LOAD;
            else if (state == WAIT && wait_cnt != 3'd0)
                wait_cnt <= wait_cnt - 3'd1;
            // Captured alongside the read strobe so read-side-effect fields return their old value
            if (state == STROBE)
                prdata <= (mapped_q && !write_q) ? rdata_sel : '0;
        end
    end

    assign rdata_sel = reg_rdata[int'(idx_q)*DATA_W +: DATA_W];

    always_comb begin
        reg_wmask = '0;
        for (int b = 0; b < NBYTES; b++)
            reg_wmask[b*8 +: 8] = {8{strb_q[b]}};
    end

    assign strobe    = (state == STROBE) && mapped_q && !noop_q;
    assign reg_acc   = strobe ? (NREGS'(1) << idx_q) : '0;
    assign reg_rd    = strobe && !write_q;
    assign reg_wr    = strobe && write_q;
    assign reg_wdata = wdata_q;
    assign pready    = (state == DONE);
    assign pslverr   = (state == DONE) && (ERR_UNMAPPED != 0) && !mapped_q;
endmodule

// File: tb/tb_srdl_apb_regif.sv
// Directed bench for srdl_apb_regif: three instances cover zero/three/four wait states and
// both error-reporting settings; expected values are hand-computed constants.
module tb_srdl_apb_regif;
    logic        clk = 1'b0;
    logic        rst;
    logic        psel, penable, pwrite;
    logic [11:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [255:0] reg_rdata;
    logic [31:0] regv [8];
    logic [31:0] r0val;
    logic        clr_arm;
    logic        cleared = 1'b0;
    int          dsel;

    int tests = 0;
    int fails = 0;

    logic        a_pready, a_pslverr, a_rd, a_wr;
    logic [31:0] a_prdata, a_wdata, a_wmask;
    logic [7:0]  a_acc;
    logic        b_pready, b_pslverr, b_rd, b_wr;
    logic [31:0] b_prdata, b_wdata, b_wmask;
    logic [7:0]  b_acc;
    logic        c_pready, c_pslverr, c_rd, c_wr;
    logic [31:0] c_prdata, c_wdata, c_wmask;
    logic [7:0]  c_acc;

    logic        o_pready, o_pslverr, o_rd, o_wr;
    logic [31:0] o_prdata, o_wdata, o_wmask;
    logic [7:0]  o_acc;

    int          rdy_c, nstb, stb_c, npready, perr_bad;
    logic [7:0]  s_acc;
    logic        s_rd, s_wr, err;
    logic [31:0] s_wdata, s_wmask, rd;

    always #5 clk = ~clk;

    srdl_apb_regif #(.WAIT_STATES(0), .ERR_UNMAPPED(1)) u_a (
        .clk(clk), .rst(rst), .psel(psel && dsel == 0), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(a_pready), .prdata(a_prdata),
        .pslverr(a_pslverr), .reg_acc(a_acc), .reg_rd(a_rd), .reg_wr(a_wr),
        .reg_wdata(a_wdata), .reg_wmask(a_wmask), .reg_rdata(reg_rdata));

    srdl_apb_regif #(.WAIT_STATES(3), .ERR_UNMAPPED(0)) u_b (
        .clk(clk), .rst(rst), .psel(psel && dsel == 1), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(b_pready), .prdata(b_prdata),
        .pslverr(b_pslverr), .reg_acc(b_acc), .reg_rd(b_rd), .reg_wr(b_wr),
        .reg_wdata(b_wdata), .reg_wmask(b_wmask), .reg_rdata(reg_rdata));

    srdl_apb_regif #(.WAIT_STATES(4), .ERR_UNMAPPED(1)) u_c (
        .clk(clk), .rst(rst), .psel(psel && dsel == 2), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pready(c_pready), .prdata(c_prdata),
        .pslverr(c_pslverr), .reg_acc(c_acc), .reg_rd(c_rd), .reg_wr(c_wr),
        .reg_wdata(c_wdata), .reg_wmask(c_wmask), .reg_rdata(reg_rdata));

    always_comb begin
        reg_rdata = '0;
        for (int i = 1; i < 8; i++) reg_rdata[i*32 +: 32] = regv[i];
        reg_rdata[31:0] = cleared ? 32'h0 : r0val;
    end

    // Register 0 behaves as read-to-clear for instance b
    always @(posedge clk) begin
        if (!clr_arm)                cleared <= 1'b0;
        else if (b_rd && b_acc[0])   cleared <= 1'b1;
    end

    always_comb begin
        case (dsel)
            1: begin
                o_pready = b_pready; o_pslverr = b_pslverr; o_rd = b_rd; o_wr = b_wr;
                o_prdata = b_prdata; o_wdata = b_wdata; o_wmask = b_wmask; o_acc = b_acc;
            end
            2: begin
                o_pready = c_pready; o_pslverr = c_pslverr; o_rd = c_rd; o_wr = c_wr;
                o_prdata = c_prdata; o_wdata = c_wdata; o_wmask = c_wmask; o_acc = c_acc;
            end
            default: begin
                o_pready = a_pready; o_pslverr = a_pslverr; o_rd = a_rd; o_wr = a_wr;
                o_prdata = a_prdata; o_wdata = a_wdata; o_wmask = a_wmask; o_acc = a_acc;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // mode 0: normal; 1: drop psel/penable at cycle abort_at; 2: pulse rst at cycle abort_at
    task automatic xfer(input int d, input logic wr, input logic [11:0] a, input logic [31:0] wd,
                        input logic [3:0] st, input int mode, input int abort_at);
        dsel = d; rdy_c = -1; nstb = 0; stb_c = -1; npready = 0; perr_bad = 0;
        s_acc = '0; s_rd = 1'b0; s_wr = 1'b0; s_wdata = '0; s_wmask = '0; rd = '0; err = 1'b0;
        @(posedge clk); #1;
        psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = wd; pstrb = st;
        @(posedge clk); #1;
        penable = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk); #1;
            if (o_acc != 0 || o_rd || o_wr) begin
                nstb++; stb_c = c;
                s_acc = o_acc; s_rd = o_rd; s_wr = o_wr; s_wdata = o_wdata; s_wmask = o_wmask;
            end
            if (!o_pready && o_pslverr) perr_bad++;
            if (o_pready) begin
                npready++;
                if (rdy_c < 0) begin
                    rdy_c = c; rd = o_prdata; err = o_pslverr;
                end
                psel = 1'b0; penable = 1'b0;
            end
            if (mode == 1 && c == abort_at) begin
                psel = 1'b0; penable = 1'b0;
            end
            if (mode == 2 && c == abort_at) begin
                rst = 1'b1;
                #1;
                chk("rst_pready", 32'(o_pready), 32'd0);
                chk("rst_prdata", o_prdata, 32'h0);
                chk("rst_acc", 32'(o_acc), 32'd0);
                psel = 1'b0; penable = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end
        end
        psel = 1'b0; penable = 1'b0;
    endtask

    initial begin
        rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        paddr = '0; pwdata = '0; pstrb = '0; dsel = 0; clr_arm = 1'b0;
        for (int i = 0; i < 8; i++) regv[i] = 32'h1000_0000 + 32'(i);
        regv[3] = 32'hDEADBEEF;
        regv[2] = 32'h5555AAAA;
        r0val   = 32'hCAFEF00D;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pready",  32'(a_pready), 32'd0);
        chk("reset_pslverr", 32'(a_pslverr), 32'd0);
        chk("reset_acc",     32'(a_acc | b_acc | c_acc), 32'd0);
        chk("reset_prdata",  a_prdata, 32'h0);
        chk("reset_wmask",   a_wmask, 32'h0);
        chk("reset_wdata",   a_wdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        xfer(0, 1'b0, 12'h00C, 32'h0, 4'hF, 0, 0);
        chk("rd3_ready_cyc", 32'(rdy_c), 32'd2);
        chk("rd3_nstb",      32'(nstb), 32'd1);
        chk("rd3_stb_cyc",   32'(stb_c), 32'd1);
        chk("rd3_acc",       32'(s_acc), 32'h08);
        chk("rd3_rd_wr",     {30'd0, s_rd, s_wr}, 32'd2);
        chk("rd3_prdata",    rd, 32'hDEADBEEF);
        chk("rd3_err",       32'(err), 32'd0);

        xfer(0, 1'b1, 12'h004, 32'h12345678, 4'b0101, 0, 0);
        chk("wr1_ready_cyc", 32'(rdy_c), 32'd2);
        chk("wr1_nstb",      32'(nstb), 32'd1);
        chk("wr1_acc",       32'(s_acc), 32'h02);
        chk("wr1_rd_wr",     {30'd0, s_rd, s_wr}, 32'd1);
        chk("wr1_wmask",     s_wmask, 32'h00FF00FF);
        chk("wr1_wdata",     s_wdata, 32'h12345678);
        chk("wr1_prdata",    rd, 32'h0);
        chk("wr1_err",       32'(err), 32'd0);

        clr_arm = 1'b1;
        xfer(1, 1'b0, 12'h000, 32'h0, 4'hF, 0, 0);
        chk("rclr_ready_cyc", 32'(rdy_c), 32'd5);
        chk("rclr_nstb",      32'(nstb), 32'd1);
        chk("rclr_acc",       32'(s_acc), 32'h01);
        chk("rclr_prdata",    rd, 32'hCAFEF00D);
        clr_arm = 1'b0;

        xfer(0, 1'b0, 12'h020, 32'h0, 4'hF, 0, 0);
        chk("unmap_nstb",   32'(nstb), 32'd0);
        chk("unmap_cyc",    32'(rdy_c), 32'd2);
        chk("unmap_prdata", rd, 32'h0);
        chk("unmap_err",    32'(err), 32'd1);
        chk("unmap_perr",   32'(perr_bad), 32'd0);

        xfer(0, 1'b0, 12'h006, 32'h0, 4'hF, 0, 0);
        chk("misal_nstb",   32'(nstb), 32'd0);
        chk("misal_prdata", rd, 32'h0);
        chk("misal_err",    32'(err), 32'd1);

        xfer(1, 1'b0, 12'h020, 32'h0, 4'hF, 0, 0);
        chk("unmap_noerr_nstb", 32'(nstb), 32'd0);
        chk("unmap_noerr_cyc",  32'(rdy_c), 32'd5);
        chk("unmap_noerr_err",  32'(err), 32'd0);

        xfer(0, 1'b1, 12'h008, 32'hFFFFFFFF, 4'b0000, 0, 0);
        chk("noop_nstb", 32'(nstb), 32'd0);
        chk("noop_cyc",  32'(rdy_c), 32'd2);
        chk("noop_err",  32'(err), 32'd0);

        xfer(2, 1'b0, 12'h008, 32'h0, 4'hF, 2, 3);
        chk("rstabort_nstb",   32'(nstb), 32'd1);
        chk("rstabort_pready", 32'(npready), 32'd0);

        xfer(2, 1'b0, 12'h00C, 32'h0, 4'hF, 0, 0);
        chk("post_rst_cyc",    32'(rdy_c), 32'd6);
        chk("post_rst_nstb",   32'(nstb), 32'd1);
        chk("post_rst_acc",    32'(s_acc), 32'h08);
        chk("post_rst_prdata", rd, 32'hDEADBEEF);

        xfer(2, 1'b0, 12'h008, 32'h0, 4'hF, 1, 3);
        chk("drop_nstb",   32'(nstb), 32'd1);
        chk("drop_pready", 32'(npready), 32'd0);

        xfer(2, 1'b0, 12'h008, 32'h0, 4'hF, 0, 0);
        chk("post_drop_cyc",    32'(rdy_c), 32'd6);
        chk("post_drop_nstb",   32'(nstb), 32'd1);
        chk("post_drop_acc",    32'(s_acc), 32'h04);
        chk("post_drop_prdata", rd, 32'h5555AAAA);
        chk("post_drop_npready", 32'(npready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
